// File: rtl/path_coord_bridge.sv
// Coordinate FIFO between the path writer and an Avalon-MM slave; readdata is registered (1 cycle).
// Upstream ready is !full only; DATA reads pop one entry, empty reads flag underflow.

module sync_fifo #(
   parameter int DW    = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr,
   input  logic                     push_vld,
   input  logic [DW-1:0]            push_dat,
   input  logic                     pop_vld,
   output logic [DW-1:0]            pop_dat,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign push_ok = push_vld && !full;
   assign pop_ok  = pop_vld && !empty;
   assign pop_dat = mem[rd_ptr];

   // Storage is left unreset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

module path_coord_bridge #(
   parameter int DEPTH = 128
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        gave_coord,
   input  logic [31:0] coord,
   output logic        received_coord,
   input  logic        finished,
   input  logic [1:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata
);
   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
   } coord_t;

   coord_t        head_dat;
   logic [CW-1:0] fifo_count;
   logic          fifo_empty;
   logic          fifo_full;
   logic          clr;
   logic          push_vld;
   logic          data_rd;
   logic          pop_vld;
   logic          done;
   logic          underflow;
   logic [15:0]   total;
   logic [31:0]   occ_wide;
   logic [7:0]    occ_sat;
   logic [31:0]   rd_mux;
   logic          unused_wdata;

   assign unused_wdata   = ^writedata[31:1];
   assign clr            = write && (address == 2'd2) && writedata[0];
   // A clear swallows a coincident push, but the writer still sees ready.
   assign push_vld       = gave_coord && !fifo_full && !clr;
   assign data_rd        = read && (address == 2'd1);
   assign pop_vld        = data_rd && !fifo_empty;
   assign received_coord = !fifo_full;

   sync_fifo #(.DW(32), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .clr      (clr),
      .push_vld (push_vld),
      .push_dat (coord),
      .pop_vld  (pop_vld),
      .pop_dat  (head_dat),
      .count    (fifo_count),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   always_comb begin
      occ_wide = 32'(fifo_count);
      occ_sat  = (occ_wide > 32'd255) ? 8'hFF : occ_wide[7:0];
      rd_mux   = '0;
      case (address)
         2'd0:    rd_mux = {16'h0, occ_sat, 4'h0, underflow, done, fifo_full, fifo_empty};
         2'd1:    rd_mux = pop_vld ? head_dat : 32'h0;
         2'd3:    rd_mux = {16'h0, total};
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done      <= 1'b0;
         underflow <= 1'b0;
         total     <= '0;
         readdata  <= '0;
      end else begin
         if (clr) begin
            done      <= 1'b0;
            underflow <= 1'b0;
            total     <= '0;
         end else begin
            if (finished)              done      <= 1'b1;
            if (data_rd && fifo_empty) underflow <= 1'b1;
            if (push_vld)              total     <= total + 16'd1;
         end
         if (read) readdata <= rd_mux;
      end
   end
endmodule

// File: doc/path_coord_bridge.md
# path_coord_bridge

Buffers the coordinate stream produced by the path writer and exposes it to the HPS over an Avalon-MM slave. Each accepted `{x, y}` coordinate is pushed into an internal FIFO and software pops entries one at a time through a data register. Sticky status flags report path completion and underflow, and a control register lets software flush the buffer before the next path is requested. The block sits between the path writer and the lightweight HPS-to-FPGA bridge.

## Interface
- `DEPTH`, default 128: FIFO depth in coordinates; a power of two ≥ 2 (covers a 100-entry path).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `gave_coord`  in  1  writer has a valid coordinate on `coord`.
- `coord`  in  32  coordinate; x in [31:16], y in [15:0].
- `received_coord`  out  1  bridge can accept a coordinate (level-sensitive ready).
- `finished`  in  1  single-cycle pulse from the writer after the last coordinate.
- `address`  in  2  Avalon word address.
- `read`  in  1  Avalon read strobe.
- `write`  in  1  Avalon write strobe.
- `writedata`  in  32  Avalon write data.
- `readdata`  out  32  Avalon read data, registered.

## Operation
- Upstream transfer: a push occurs on any rising edge where `gave_coord && received_coord`.
- `received_coord = !full`. This is combinational from FIFO state only, never from Avalon inputs.
- Register map:
  - addr 0 STATUS (read): [0] empty, [1] full, [2] done, [3] underflow, [15:8] occupancy (saturates at 255), others 0.
  - addr 1 DATA (read): returns the head coordinate and pops it.
  - addr 2 CONTROL (write): bit0=1 triggers a clear. Reads return 0.
  - addr 3 TOTAL (read): 16-bit count of pushes since the last clear, zero-extended. It wraps at 0xFFFF→0.
- Pop behaviour:
  - A DATA read with the FIFO non-empty pops the head entry.
  - A DATA read with the FIFO empty returns 0, sets underflow, and leaves the pointers unchanged.
- done flag: set by a `finished` pulse, sticky until cleared.
- Clear:
  - Resets both pointers, occupancy, done, underflow and TOTAL.
  - Clear has priority: a push or a `finished` pulse in the same cycle is discarded. The writer still sees the handshake complete.
- Same-cycle push and pop: both take effect and occupancy is unchanged. This is legal when full, because `received_coord` is low when full, so no push can occur.
- Writes to addresses 0, 1 and 3 are ignored. Simultaneous `read` and `write` on the same cycle: both are serviced independently.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits, so full and empty are distinguished.

## Timing
- Reset values: `received_coord`=1, `readdata`=0, FIFO empty, done=0, underflow=0, TOTAL=0.
- A reset asserted mid-stream discards all buffered data immediately (asynchronous).
- Read latency is 1 cycle: `readdata` is valid on the cycle after `read` and holds until the next read.
- A coordinate pushed in cycle N is readable by a DATA read issued in cycle N+1.
- The STATUS and TOTAL reflect the effect of a push in cycle N from a read issued in cycle N+1.
- `received_coord` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the pop that frees a slot.
- Clear takes effect on the edge of the write. The next cycle shows empty=1, done=0 and `received_coord`=1.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- **Stream and drain:** hold `gave_coord`=1 and push 3 coordinates 0x00100010, 0x00160020, 0x00820043, then pulse `finished`.
  - STATUS reads 0x00000304 (occupancy 3, done).
  - Three DATA reads return the coordinates in order.
  - STATUS then reads 0x00000005.
- **Fill to DEPTH:** with DEPTH=128 and no pops, push 128 coordinates.
  - `received_coord` goes 0 the cycle after the 128th push, and the 129th coordinate is held.
  - One DATA read releases it; TOTAL reads 129.
- **Underflow:** DATA read on an empty FIFO returns 0x00000000 and STATUS bit3=1. A following clear returns STATUS to 0x00000001.
- **Simultaneous push and pop** at occupancy 5 for 10 cycles: occupancy stays 5 and readdata follows FIFO order.
- **Clear collision:** a CONTROL write of 1 in the same cycle as a push and a `finished` pulse leaves STATUS=0x00000001 and TOTAL=0.
- **Reset mid-operation:** drop `reset` to 0 with 50 entries buffered.
  - Outputs return to reset values without waiting for a clock edge.
  - After release, the next push lands at occupancy 1.
